// File: rtl/memory_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage_if
//  Description : Wishbone-style master bus bundle used by the memory stage.
//                Master modport drives the cycle/strobe/address/data/select
//                lines and receives ack and read data; slave is the mirror.
//  Signals     : cyc_o, stb_o, wbwe_o, sel_o[7:0], adr_o[63:0], wbdat_o[63:0]
//                (master -> slave); ack_i, wbdat_i[63:0] (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_stage_if;
  logic        cyc_o;
  logic        stb_o;
  logic        wbwe_o;
  logic [7:0]  sel_o;
  logic [63:0] adr_o;
  logic [63:0] wbdat_o;
  logic        ack_i;
  logic [63:0] wbdat_i;

  modport master (
    output cyc_o, stb_o, wbwe_o, sel_o, adr_o, wbdat_o,
    input  ack_i, wbdat_i
  );

  modport slave (
    input  cyc_o, stb_o, wbwe_o, sel_o, adr_o, wbdat_o,
    output ack_i, wbdat_i
  );
endinterface
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_stage
//  Description : Pipeline memory stage. Accepts a request from execute,
//                either forwards a non-memory result straight to writeback or
//                runs one Wishbone-style bus cycle (byte-lane aligned load or
//                store) and writes load data back, sign/zero extended.
//  Ports       : clk_i, reset_i (sync, active-high)
//                rd_i, addr_i, we_i, nomem_i, mem_i, dat_i, xrs_rwe_i : request
//                busy_o                                 : stall to execute
//                wb (memory_stage_if.master)            : bus master
//                wb_rd_o, wb_dat_o, wb_we_o             : register writeback
//                align_fault_o (only with MISALIGN_TRAP_EN)
//  Config      : MISALIGN_TRAP_EN - when defined, misaligned accesses trap
//                (align_fault_o pulse, no bus cycle); otherwise they are
//                aligned down to the access size.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_stage (
  input  wire logic          clk_i,
  input  wire logic          reset_i,
  input  wire logic [4:0]    rd_i,
  input  wire logic [63:0]   addr_i,
  input  wire logic          we_i,
  input  wire logic          nomem_i,
  input  wire logic          mem_i,
  input  wire logic [63:0]   dat_i,
  input  wire logic [2:0]    xrs_rwe_i,
  output logic               busy_o,
  memory_stage_if.master     wb,
  output logic [4:0]         wb_rd_o,
  output logic [63:0]        wb_dat_o,
  output logic               wb_we_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic               align_fault_o
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  state_t      r_state, w_state_nx;
  logic        r_cyc, w_cyc_nx;
  logic        r_wbwe, w_wbwe_nx;
  logic [7:0]  r_sel, w_sel_nx;
  logic [63:0] r_adr, w_adr_nx;
  logic [63:0] r_wbdat, w_wbdat_nx;
  logic        r_wb_we, w_wb_we_nx;
  logic [4:0]  r_wb_rd, w_wb_rd_nx;
  logic [63:0] r_wb_dat, w_wb_dat_nx;
  // Captured load context for the completion edge
  logic [4:0]  r_rd, w_rd_nx;
  logic [2:0]  r_off, w_off_nx;
  logic [2:0]  r_rwe, w_rwe_nx;
  // One-entry holding slot for a non-memory result that collides with a load
  // writeback on the ack edge; it drains on the following cycle.
  logic        r_pend_vld, w_pend_vld_nx;
  logic [4:0]  r_pend_rd, w_pend_rd_nx;
  logic [63:0] r_pend_dat, w_pend_dat_nx;
`ifdef MISALIGN_TRAP_EN
  logic        r_fault, w_fault_nx;
  logic        w_misal;
`endif

  logic        w_done;
  logic        w_accept;
  logic        w_is_mem;
  logic        w_nomem_acc;
  logic        w_bus_start;
  logic [2:0]  w_szm;      // access size in bytes minus one
  logic [7:0]  w_bytes;    // unshifted byte-lane mask
  logic [63:0] w_lanemask; // unshifted bit mask for store data
  logic [2:0]  w_off;
  logic [63:0] w_shift;
  logic [63:0] w_ld;

  assign w_done      = (r_state == S_BUS) && wb.ack_i;
  assign w_accept    = (r_state == S_IDLE) || w_done;
  assign w_is_mem    = mem_i && (xrs_rwe_i != 3'b000);
  assign w_nomem_acc = w_accept && !mem_i && nomem_i;

  always_comb begin
    w_szm      = 3'd0;
    w_bytes    = 8'h01;
    w_lanemask = 64'h0000_0000_0000_00FF;
    unique case (xrs_rwe_i)
      3'b010, 3'b110: begin
        w_szm      = 3'd1;
        w_bytes    = 8'h03;
        w_lanemask = 64'h0000_0000_0000_FFFF;
      end
      3'b011, 3'b111: begin
        w_szm      = 3'd3;
        w_bytes    = 8'h0F;
        w_lanemask = 64'h0000_0000_FFFF_FFFF;
      end
      3'b100: begin
        w_szm      = 3'd7;
        w_bytes    = 8'hFF;
        w_lanemask = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      default: ;
    endcase
  end

  // Offset is aligned down to the access size; with trapping enabled a
  // misaligned access never reaches the bus so the same value is used.
  assign w_off = addr_i[2:0] & ~w_szm;

`ifdef MISALIGN_TRAP_EN
  assign w_misal     = |(addr_i[2:0] & w_szm);
  assign w_bus_start = w_accept && w_is_mem && !w_misal;
`else
  assign w_bus_start = w_accept && w_is_mem;
`endif

  // Load lane extraction from the captured offset and size/sign code
  assign w_shift = wb.wbdat_i >> {r_off, 3'b000};
  always_comb begin
    w_ld = w_shift;
    unique case (r_rwe)
      3'b001:  w_ld = {{56{w_shift[7]}},  w_shift[7:0]};
      3'b010:  w_ld = {{48{w_shift[15]}}, w_shift[15:0]};
      3'b011:  w_ld = {{32{w_shift[31]}}, w_shift[31:0]};
      3'b101:  w_ld = {56'd0, w_shift[7:0]};
      3'b110:  w_ld = {48'd0, w_shift[15:0]};
      3'b111:  w_ld = {32'd0, w_shift[31:0]};
      default: w_ld = w_shift;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nx    = r_state;
    w_cyc_nx      = r_cyc;
    w_wbwe_nx     = r_wbwe;
    w_sel_nx      = r_sel;
    w_adr_nx      = r_adr;
    w_wbdat_nx    = r_wbdat;
    w_rd_nx       = r_rd;
    w_off_nx      = r_off;
    w_rwe_nx      = r_rwe;
    w_wb_we_nx    = 1'b0;
    w_wb_rd_nx    = r_wb_rd;
    w_wb_dat_nx   = r_wb_dat;
    w_pend_vld_nx = 1'b0;
    w_pend_rd_nx  = r_pend_rd;
    w_pend_dat_nx = r_pend_dat;
`ifdef MISALIGN_TRAP_EN
    w_fault_nx    = w_accept && w_is_mem && w_misal;
`endif

    if (w_done) begin
      w_state_nx = S_IDLE;
      w_cyc_nx   = 1'b0;
    end

    if (w_bus_start) begin
      w_state_nx = S_BUS;
      w_cyc_nx   = 1'b1;
      w_wbwe_nx  = we_i;
      w_sel_nx   = w_bytes << w_off;
      w_adr_nx   = {addr_i[63:3], 3'b000};
      w_wbdat_nx = (dat_i & w_lanemask) << {w_off, 3'b000};
      w_rd_nx    = rd_i;
      w_off_nx   = w_off;
      w_rwe_nx   = xrs_rwe_i;
    end

    // Writeback arbitration: load completion first, then held result, then
    // a freshly accepted non-memory result.
    if (w_done && !r_wbwe) begin
      w_wb_we_nx  = 1'b1;
      w_wb_rd_nx  = r_rd;
      w_wb_dat_nx = w_ld;
      if (w_nomem_acc) begin
        w_pend_vld_nx = 1'b1;
        w_pend_rd_nx  = rd_i;
        w_pend_dat_nx = addr_i;
      end
    end else if (r_pend_vld) begin
      w_wb_we_nx  = 1'b1;
      w_wb_rd_nx  = r_pend_rd;
      w_wb_dat_nx = r_pend_dat;
      if (w_nomem_acc) begin
        w_pend_vld_nx = 1'b1;
        w_pend_rd_nx  = rd_i;
        w_pend_dat_nx = addr_i;
      end
    end else if (w_nomem_acc) begin
      w_wb_we_nx  = 1'b1;
      w_wb_rd_nx  = rd_i;
      w_wb_dat_nx = addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_cyc      <= 1'b0;
      r_wbwe     <= 1'b0;
      r_sel      <= 8'h00;
      r_adr      <= 64'd0;
      r_wbdat    <= 64'd0;
      r_rd       <= 5'd0;
      r_off      <= 3'd0;
      r_rwe      <= 3'd0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_dat   <= 64'd0;
      r_pend_vld <= 1'b0;
      r_pend_rd  <= 5'd0;
      r_pend_dat <= 64'd0;
`ifdef MISALIGN_TRAP_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_cyc      <= w_cyc_nx;
      r_wbwe     <= w_wbwe_nx;
      r_sel      <= w_sel_nx;
      r_adr      <= w_adr_nx;
      r_wbdat    <= w_wbdat_nx;
      r_rd       <= w_rd_nx;
      r_off      <= w_off_nx;
      r_rwe      <= w_rwe_nx;
      r_wb_we    <= w_wb_we_nx;
      r_wb_rd    <= w_wb_rd_nx;
      r_wb_dat   <= w_wb_dat_nx;
      r_pend_vld <= w_pend_vld_nx;
      r_pend_rd  <= w_pend_rd_nx;
      r_pend_dat <= w_pend_dat_nx;
`ifdef MISALIGN_TRAP_EN
      r_fault    <= w_fault_nx;
`endif
    end
  end

  assign busy_o     = (r_state == S_BUS) && !wb.ack_i;
  assign wb.cyc_o   = r_cyc;
  assign wb.stb_o   = r_cyc;
  assign wb.wbwe_o  = r_wbwe;
  assign wb.sel_o   = r_sel;
  assign wb.adr_o   = r_adr;
  assign wb.wbdat_o = r_wbdat;
  assign wb_we_o    = r_wb_we;
  assign wb_rd_o    = r_wb_rd;
  assign wb_dat_o   = r_wb_dat;
`ifdef MISALIGN_TRAP_EN
  assign align_fault_o = r_fault;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_stage
//  Description : Directed self-checking bench for memory_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

  logic        clk_i;
  logic        reset_i;
  logic [4:0]  rd_i;
  logic [63:0] addr_i;
  logic        we_i;
  logic        nomem_i;
  logic        mem_i;
  logic [63:0] dat_i;
  logic [2:0]  xrs_rwe_i;
  logic        busy_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_dat_o;
  logic        wb_we_o;
`ifdef MISALIGN_TRAP_EN
  logic        align_fault_o;
`endif

  int n_cmp;
  int n_err;

  memory_stage_if bus ();

  memory_stage dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .rd_i      (rd_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .nomem_i   (nomem_i),
    .mem_i     (mem_i),
    .dat_i     (dat_i),
    .xrs_rwe_i (xrs_rwe_i),
    .busy_o    (busy_o),
    .wb        (bus),
    .wb_rd_o   (wb_rd_o),
    .wb_dat_o  (wb_dat_o),
    .wb_we_o   (wb_we_o)
`ifdef MISALIGN_TRAP_EN
    ,
    .align_fault_o (align_fault_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    rd_i      = 5'd0;
    addr_i    = 64'd0;
    we_i      = 1'b0;
    nomem_i   = 1'b0;
    mem_i     = 1'b0;
    dat_i     = 64'd0;
    xrs_rwe_i = 3'b000;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_i     = 1'b1;
    bus.ack_i   = 1'b0;
    bus.wbdat_i = 64'd0;
    clear_req();
    tick();
    tick();

    // Reset state
    check("rst_cyc",    {63'd0, bus.cyc_o},  64'd0);
    check("rst_stb",    {63'd0, bus.stb_o},  64'd0);
    check("rst_wbwe",   {63'd0, bus.wbwe_o}, 64'd0);
    check("rst_sel",    {56'd0, bus.sel_o},  64'd0);
    check("rst_adr",    bus.adr_o,           64'd0);
    check("rst_wbdat",  bus.wbdat_o,         64'd0);
    check("rst_wb_we",  {63'd0, wb_we_o},    64'd0);
    check("rst_wb_rd",  {59'd0, wb_rd_o},    64'd0);
    check("rst_wb_dat", wb_dat_o,            64'd0);
    check("rst_busy",   {63'd0, busy_o},     64'd0);
`ifdef MISALIGN_TRAP_EN
    check("rst_fault",  {63'd0, align_fault_o}, 64'd0);
`endif
    reset_i = 1'b0;

    // Non-memory forward
    nomem_i = 1'b1; addr_i = 64'hDFF800; rd_i = 5'd23;
    tick();
    clear_req();
    check("nm_we",  {63'd0, wb_we_o},   64'd1);
    check("nm_rd",  {59'd0, wb_rd_o},   64'd23);
    check("nm_dat", wb_dat_o,           64'hDFF800);
    check("nm_cyc", {63'd0, bus.cyc_o}, 64'd0);
    tick();
    check("nm_pulse", {63'd0, wb_we_o}, 64'd0);

    // Load S16 at offset 2, three busy cycles then ack
    mem_i = 1'b1; we_i = 1'b0; xrs_rwe_i = 3'b010; addr_i = 64'h3FF802; rd_i = 5'd19;
    tick();
    clear_req();
    nomem_i = 1'b1; addr_i = 64'h1234; rd_i = 5'd2;   // must be ignored while busy
    check("ld16_cyc",  {63'd0, bus.cyc_o},  64'd1);
    check("ld16_stb",  {63'd0, bus.stb_o},  64'd1);
    check("ld16_sel",  {56'd0, bus.sel_o},  64'h0C);
    check("ld16_adr",  bus.adr_o,           64'h3FF800);
    check("ld16_wbwe", {63'd0, bus.wbwe_o}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("ld16_busy",  {63'd0, busy_o},  64'd1);
      check("ld16_nowb",  {63'd0, wb_we_o}, 64'd0);
      check("ld16_hold",  bus.adr_o,        64'h3FF800);
      if (i == 2) clear_req();
      tick();
    end
    bus.ack_i = 1'b1; bus.wbdat_i = 64'h0000_0000_8001_0000;
    #1;
    check("ld16_busy_ack", {63'd0, busy_o}, 64'd0);
    tick();
    bus.ack_i = 1'b0;
    check("ld16_we",  {63'd0, wb_we_o},   64'd1);
    check("ld16_rd",  {59'd0, wb_rd_o},   64'd19);
    check("ld16_dat", wb_dat_o,           64'hFFFF_FFFF_FFFF_8001);
    check("ld16_end", {63'd0, bus.cyc_o}, 64'd0);
    tick();
    check("ld16_pulse", {63'd0, wb_we_o}, 64'd0);

    // Store S8 at offset 5
    mem_i = 1'b1; we_i = 1'b1; xrs_rwe_i = 3'b001; addr_i = 64'h400005; dat_i = 64'hFACE; rd_i = 5'd5;
    tick();
    clear_req();
    check("st8_sel",   {56'd0, bus.sel_o},  64'h20);
    check("st8_wbdat", bus.wbdat_o,         64'h0000_CE00_0000_0000);
    check("st8_wbwe",  {63'd0, bus.wbwe_o}, 64'd1);
    check("st8_adr",   bus.adr_o,           64'h400000);
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    check("st8_nowb", {63'd0, wb_we_o},   64'd0);
    check("st8_end",  {63'd0, bus.cyc_o}, 64'd0);

    // Load U16 at offset 6, nomem presented on the ack edge
    mem_i = 1'b1; we_i = 1'b0; xrs_rwe_i = 3'b110; addr_i = 64'h1006; rd_i = 5'd7;
    tick();
    clear_req();
    check("ldu16_sel", {56'd0, bus.sel_o}, 64'hC0);
    bus.ack_i = 1'b1; bus.wbdat_i = 64'h8123_0000_0000_0000;
    nomem_i = 1'b1; addr_i = 64'hABC; rd_i = 5'd9;
    tick();
    bus.ack_i = 1'b0;
    clear_req();
    check("b2b_we1",  {63'd0, wb_we_o}, 64'd1);
    check("b2b_rd1",  {59'd0, wb_rd_o}, 64'd7);
    check("b2b_dat1", wb_dat_o,         64'h8123);
    tick();
    check("b2b_we2",  {63'd0, wb_we_o}, 64'd1);
    check("b2b_rd2",  {59'd0, wb_rd_o}, 64'd9);
    check("b2b_dat2", wb_dat_o,         64'hABC);
    tick();
    check("b2b_idle", {63'd0, wb_we_o}, 64'd0);

    // Bubble: mem with size 000 (and nomem also set; mem has priority)
    mem_i = 1'b1; nomem_i = 1'b1; xrs_rwe_i = 3'b000; addr_i = 64'h55; rd_i = 5'd1;
    tick();
    clear_req();
    check("bub_we",  {63'd0, wb_we_o},   64'd0);
    check("bub_cyc", {63'd0, bus.cyc_o}, 64'd0);

    // mem+nomem with real size: bus cycle, rd=0 forwarded later is irrelevant
    mem_i = 1'b1; nomem_i = 1'b1; xrs_rwe_i = 3'b100; addr_i = 64'h2000; rd_i = 5'd3;
    tick();
    clear_req();
    check("prio_cyc", {63'd0, bus.cyc_o}, 64'd1);
    check("prio_sel", {56'd0, bus.sel_o}, 64'hFF);
    check("prio_we",  {63'd0, wb_we_o},   64'd0);

    // Reset mid-BUS, late ack ignored
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    bus.ack_i = 1'b1; bus.wbdat_i = 64'hDEAD_BEEF_0000_0001;
    #1;
    check("rstbus_cyc",  {63'd0, bus.cyc_o}, 64'd0);
    check("rstbus_busy", {63'd0, busy_o},    64'd0);
    check("rstbus_we",   {63'd0, wb_we_o},   64'd0);
    tick();
    bus.ack_i = 1'b0;
    check("rstbus_we2",  {63'd0, wb_we_o},   64'd0);
    check("rstbus_cyc2", {63'd0, bus.cyc_o}, 64'd0);

    // rd=0 is still forwarded
    nomem_i = 1'b1; addr_i = 64'h77; rd_i = 5'd0;
    tick();
    clear_req();
    check("rd0_we",  {63'd0, wb_we_o}, 64'd1);
    check("rd0_dat", wb_dat_o,         64'h77);

    // S32 at a misaligned address
    mem_i = 1'b1; we_i = 1'b0; xrs_rwe_i = 3'b011; addr_i = 64'hE00002; rd_i = 5'd4;
    tick();
    clear_req();
`ifdef MISALIGN_TRAP_EN
    check("mis_fault", {63'd0, align_fault_o}, 64'd1);
    check("mis_cyc",   {63'd0, bus.cyc_o},     64'd0);
    check("mis_we",    {63'd0, wb_we_o},       64'd0);
    tick();
    check("mis_fault_end", {63'd0, align_fault_o}, 64'd0);
`else
    check("mis_cyc", {63'd0, bus.cyc_o}, 64'd1);
    check("mis_adr", bus.adr_o,          64'hE00000);
    check("mis_sel", {56'd0, bus.sel_o}, 64'h0F);
    bus.ack_i = 1'b1; bus.wbdat_i = 64'h1111_2222_8000_0001;
    tick();
    bus.ack_i = 1'b0;
    check("mis_we",  {63'd0, wb_we_o}, 64'd1);
    check("mis_rd",  {59'd0, wb_rd_o}, 64'd4);
    check("mis_dat", wb_dat_o,         64'hFFFF_FFFF_8000_0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have port clk_i  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports rd_i in 5, addr_i in 64, we_i in 1, nomem_i in 1, mem_i in 1, dat_i in 64, xrs_rwe_i in 3; these are the request from the execute stage.
REQ-004 SHALL have port busy_o  out  1  stall to execute stage; request inputs ignored while high.
REQ-005 SHALL have Wishbone-style master ports cyc_o out 1, stb_o out 1, wbwe_o out 1, sel_o out 8, adr_o out 64, wbdat_o out 64, ack_i in 1, wbdat_i in 64.
REQ-006 SHALL have writeback ports wb_rd_o out 5, wb_dat_o out 64, wb_we_o out 1 (register-file write strobe, one cycle).
REQ-007 SHALL use xrs_rwe encoding: 000 none, 001 S8, 010 S16, 011 S32, 100 S64, 101 U8, 110 U16, 111 U32.

Function
REQ-008 SHALL implement states IDLE and BUS; request accepted only in IDLE.
REQ-009 nomem_i=1 in IDLE: next edge wb_we_o=1, wb_rd_o=rd_i, wb_dat_o=addr_i; state stays IDLE; no bus cycle.
REQ-010 mem_i=1 with xrs_rwe_i!=000 in IDLE: next edge enter BUS with cyc_o=stb_o=1, adr_o={addr_i[63:3],3'b000}, wbwe_o=we_i, sel_o and wbdat_o per REQ-011/012.
REQ-011 sel_o SHALL be byte-lane mask: size 1/2/4/8 bytes shifted left by addr_i[2:0] (e.g. S16 at offset 2 -> 8'h0C).
REQ-012 Stores SHALL place dat_i low bytes into addressed lanes (wbdat_o = dat_i << 8*addr_i[2:0]); unused lanes zero.
REQ-013 busy_o SHALL equal (state==BUS) && !ack_i; combinational.
REQ-014 In BUS, outputs SHALL hold stable until ack_i=1; on the ack edge cyc_o=stb_o=0, state -> IDLE.
REQ-015 Load completion: on ack edge wb_we_o=1, wb_rd_o=captured rd, wb_dat_o = lane-extracted wbdat_i, sign-extended (S*) or zero-extended (U*, S64 unextended).
REQ-016 Store completion SHALL pulse nothing on writeback (wb_we_o=0).
REQ-017 Request inputs arriving on the same edge as ack_i SHALL be accepted (back-to-back, zero bubble).
REQ-018 rd=0 SHALL still be forwarded; suppression is the register file's duty.
REQ-019 mem_i and nomem_i both 0, or mem_i=1 with xrs_rwe_i=000, SHALL be a bubble: wb_we_o=0 next cycle.
REQ-020 mem_i and nomem_i both 1 SHALL be treated as mem_i (mem takes priority).

Reset
REQ-021 reset_i high at edge SHALL force IDLE, cyc_o=stb_o=wbwe_o=0, sel_o=0, adr_o=0, wbdat_o=0, wb_we_o=0, wb_rd_o=0, wb_dat_o=0, align_fault_o=0.
REQ-022 Reset during BUS SHALL abandon the cycle; a late ack_i after reset SHALL be ignored.

Configuration
REQ-023 Macro MISALIGN_TRAP_EN defined: port align_fault_o out 1 exists; access with addr_i not a multiple of its size SHALL issue no bus cycle and pulse align_fault_o=1 for one cycle, wb_we_o=0.
REQ-024 Without MISALIGN_TRAP_EN: no align_fault_o port; misaligned address bits below size granularity SHALL be cleared (access aligned down).

Verification
REQ-025 nomem_i=1, addr_i=64'hDFF800, rd_i=23 -> next cycle wb_we_o=1, wb_rd_o=23, wb_dat_o=64'hDFF800, cyc_o=0.
REQ-026 Load S16 addr 64'h3FF802 rd 19, ack after 3 cycles with wbdat_i=64'h0000_0000_8001_0000 -> sel_o=8'h0C, adr_o=64'h3FF800, busy_o=1 for 3 cycles, then wb_dat_o=64'hFFFF_FFFF_FFFF_8001.
REQ-027 Store S8 addr 64'h400005 dat_i=64'hFACE -> sel_o=8'h20, wbdat_o=64'h0000_CE00_0000_0000, wbwe_o=1, wb_we_o=0 at ack.
REQ-028 Load U16 then nomem back-to-back on the ack edge -> both writebacks, consecutive cycles, no bubble.
REQ-029 reset_i asserted mid-BUS, ack_i pulsed next cycle -> cyc_o=0, busy_o=0, wb_we_o stays 0.
REQ-030 With MISALIGN_TRAP_EN, S32 at 64'hE00002 -> align_fault_o=1 one cycle, cyc_o=0; without, access at 64'hE00000, sel_o=8'h0F.
